// File: rtl/mem_bus_pkg.sv
// Shared types for the core-side memory bridges: bridge FSM states, bus size
// codes and the byte-enable to size-code mapping used for writes.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  // Non power-of-two enable patterns are illegal; they fall back to a word.
  function automatic logic [1:0] wen_to_size(input logic [7:0] wen);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      ones += 32'(wen[i]);
    end
    case (ones)
      1:       return SIZE_BYTE;
      2:       return SIZE_HALF;
      4:       return SIZE_WORD;
      8:       return SIZE_DWORD;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_perf.sv
// Handshake and stall-cycle counters for one bridge; both wrap at 2^32.
// Updates one cycle after the counted event, never backpressures.
module sram_like_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_hs,
  input  logic        stall_cyc,
  output logic [31:0] req_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (addr_hs)   req_cnt   <= req_cnt + 32'd1;
      if (stall_cyc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Single-cycle SRAM port to sram-like req/addr_ok/data_ok bus; stalls the core until data_ok, result held in DONE.
// Min latency: stall 2 cycles, data in cycle 3. SRAML_PERF_EN adds perf_req_cnt/perf_stall_cnt counters.
module sram_like_bridge
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned READ_SIZE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                stall,
  input  logic                longest_stall,
`ifdef SRAML_PERF_EN
  output logic [31:0]         perf_req_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  localparam logic [1:0] RD_SIZE = 2'(READ_SIZE);

  bridge_state_e       state_q;
  bridge_state_e       state_d;
  logic [DATA_W-1:0]   data_q;
  logic                is_wr;

  assign is_wr = |cpu_wen;
  assign wr    = is_wr;
  assign addr  = cpu_addr;
  assign wdata = cpu_wdata;
  assign size  = is_wr ? wen_to_size(8'(cpu_wen)) : RD_SIZE;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are gated by rst so the bus and pipeline see idle during reset.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = cpu_en;
        if (cpu_en) state_d = addr_ok ? WAIT_DATA : WAIT_ADDR;
      end
      WAIT_ADDR: begin
        req = 1'b1;
        if (addr_ok) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (data_ok) state_d = DONE;
      end
      DONE: begin
        if (!longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall = cpu_en && (state_q != DONE);
    if (rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  // Writes leave the previously read value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (state_q == WAIT_DATA && data_ok && !is_wr) begin
      data_q <= rdata;
    end
  end

  assign cpu_rdata = rst ? '0 : data_q;

`ifdef SRAML_PERF_EN
  sram_like_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .addr_hs   (req & addr_ok),
    .stall_cyc (stall),
    .req_cnt   (perf_req_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: directed and random transactions with a cycle-count reference model.
module tb_sram_like_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_en;
  logic [WW-1:0] cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          longest_stall;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;
`ifdef SRAML_PERF_EN
  logic [31:0]   perf_req_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  sram_like_bridge #(.DATA_W(DW), .ADDR_W(AW), .READ_SIZE(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_en        (cpu_en),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .stall         (stall),
    .longest_stall (longest_stall),
`ifdef SRAML_PERF_EN
    .perf_req_cnt  (perf_req_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .req           (req),
    .wr            (wr),
    .size          (size),
    .addr          (addr),
    .wdata         (wdata),
    .addr_ok       (addr_ok),
    .data_ok       (data_ok),
    .rdata         (rdata)
  );

  always #5 clk = ~clk;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_rdata;
  int unsigned   exp_req_cnt;
  int unsigned   exp_stall_cnt;

  function automatic logic [1:0] model_size(input logic [WW-1:0] wen);
    if (wen == '0) return 2'd2;
    case ($countones(wen))
      1:       return 2'd0;
      2:       return 2'd1;
      4:       return 2'd2;
      8:       return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs are already driven; check at the falling edge, then advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic e_req, input logic e_stall);
    @(negedge clk);
    check({tag, ".req"},   64'(req),       64'(e_req));
    check({tag, ".stall"}, 64'(stall),     64'(e_stall));
    check({tag, ".rdata"}, 64'(cpu_rdata), 64'(exp_rdata));
    if (cpu_en) begin
      check({tag, ".wr"},    64'(wr),    64'(|cpu_wen));
      check({tag, ".size"},  64'(size),  64'(model_size(cpu_wen)));
      check({tag, ".addr"},  64'(addr),  64'(cpu_addr));
      check({tag, ".wdata"}, 64'(wdata), 64'(cpu_wdata));
    end
    @(posedge clk);
    #1;
  endtask

  // da: cycles of waiting before addr_ok; dd: cycles from addr_ok to data_ok; hold: extra DONE cycles.
  task automatic run_txn(input string tag, input logic [WW-1:0] wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int da, input int dd, input int hold, input bit spur);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
    longest_stall = 1'b1;
    for (int k = 0; k <= da; k++) begin
      addr_ok = (k == da);
      data_ok = (k < da) && spur && ($urandom_range(0, 1) == 1);
      rdata   = $urandom;
      cycle({tag, ".addr"}, 1'b1, 1'b1);
      exp_stall_cnt++;
    end
    exp_req_cnt++;
    for (int j = 1; j <= dd; j++) begin
      addr_ok = 1'b0;
      data_ok = (j == dd);
      rdata   = (j == dd) ? rd : DW'($urandom);
      cycle({tag, ".data"}, 1'b0, 1'b1);
      exp_stall_cnt++;
    end
    if (wen == '0) exp_rdata = rd;
    for (int h = 0; h <= hold; h++) begin
      addr_ok       = 1'b0;
      longest_stall = (h < hold);
      data_ok       = spur && ($urandom_range(0, 1) == 1);
      rdata         = $urandom;
      cycle({tag, ".done"}, 1'b0, 1'b0);
    end
    data_ok = 1'b0; longest_stall = 1'b0;
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      cpu_en        = 1'b0;
      cpu_wen       = WW'($urandom);
      cpu_addr      = $urandom;
      addr_ok       = 1'b0;
      data_ok       = spur && ($urandom_range(0, 1) == 1);
      rdata         = $urandom;
      longest_stall = ($urandom_range(0, 1) == 1);
      cycle("idle", 1'b0, 1'b0);
    end
    data_ok = 1'b0; longest_stall = 1'b0;
  endtask

  task automatic check_perf(input string tag);
`ifdef SRAML_PERF_EN
    @(negedge clk);
    check({tag, ".perf_req"},   64'(perf_req_cnt),   64'(exp_req_cnt));
    check({tag, ".perf_stall"}, 64'(perf_stall_cnt), 64'(exp_stall_cnt));
    @(posedge clk);
    #1;
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    logic [WW-1:0] wen;
    int            r;
    rst = 1'b1; cpu_en = 1'b1; cpu_wen = '0; cpu_addr = 32'h1000_0000; cpu_wdata = '0;
    longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    exp_rdata = '0; exp_req_cnt = 0; exp_stall_cnt = 0;

    // Reset holds the bus and pipeline idle even with cpu_en high.
    @(posedge clk); #1;
    cycle("reset", 1'b0, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);
    check_perf("reset");

    run_txn("rd_fast", '0, 32'h0000_0100, '0, 32'h1234_5678, 0, 1, 0, 1'b0);
    run_txn("wr_half", 4'b0011, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 3, 2, 0, 1'b0);
    run_txn("done_hold", '0, 32'h0000_0200, '0, 32'hCAFE_F00D, 1, 1, 5, 1'b0);
    run_txn("b2b_a", '0, 32'hAAAA_0000, '0, 32'h1111_AAAA, 0, 1, 0, 1'b0);
    run_txn("b2b_b", '0, 32'hBBBB_1111, '0, 32'h2222_BBBB, 0, 1, 0, 1'b0);
    $display("note: next write uses non power-of-two wen 4'b0111, expected to be coded as a word");
    run_txn("wr_odd", 4'b0111, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 0, 2, 1, 1'b0);
    run_txn("wr_byte", 4'b0100, 32'h0000_0302, 32'h0077_0000, 32'h0, 2, 1, 0, 1'b1);
    check_perf("directed");

    // Reset while waiting for data: bridge returns to idle and ignores stray data_ok.
    cpu_en = 1'b1; cpu_wen = '0; cpu_addr = 32'h0000_0400; addr_ok = 1'b1;
    cycle("rst_mid.req", 1'b1, 1'b1);
    addr_ok = 1'b0; rst = 1'b1; exp_rdata = '0;
    cycle("rst_mid.hit", 1'b0, 1'b0);
    rst = 1'b0; exp_req_cnt = 0; exp_stall_cnt = 0;
    idle(3, 1'b1);
    check_perf("rst_mid");

    // Three reads, each stalling exactly two cycles.
    for (int t = 0; t < 3; t++) begin
      run_txn("perf3", '0, 32'h0000_0500 + 32'(t * 4), '0, $urandom, 0, 1, 0, 1'b0);
    end
    check_perf("perf3");

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 5);
      case (r)
        2:       wen = WW'(1) << $urandom_range(0, WW - 1);
        3:       wen = ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b1100;
        4:       wen = 4'b1111;
        default: wen = '0;
      endcase
      run_txn("rand", wen, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3), 1'b1);
      idle($urandom_range(0, 2), 1'b1);
    end
    check_perf("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
